ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receiver that sits directly upstream of the Mac Plus core's keyboard input.
- Deserialises raw PS/2 device-to-host frames, validates them, and buffers bytes in a small FIFO.
- Delivers raw bytes (including E0/F0 prefixes) to the core as a one-cycle kbd_strobe with kbd_data.
- Translation to Mac keycodes happens downstream; this block does none.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes.
- TIMEOUT_CYC, 32000: clk cycles without a filtered falling edge, mid-frame, before the frame is aborted (about 1 ms at 32 MHz).
- FIFO_DEPTH, 4: byte FIFO depth; must be a power of 2.
- GAP_CYC, 64: minimum clk cycles between successive kbd_strobe pulses.

Ports:
- clk  in  1  system clock, 16/32 MHz
- reset_n  in  1  synchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- kbd_strobe  out  1  one-cycle pulse: kbd_data carries a new byte
- kbd_data  out  8  received byte; held stable until the next strobe
- frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error
- overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full
- busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset
  - Synchronous, active-low: sampled on the rising edge of clk while reset_n=0.
  - Reset values: kbd_strobe=0, kbd_data=8'h00, frame_err=0, overflow=0, busy=0.
  - FIFO emptied, FSM to IDLE, gap counter=0, filter state=1.
  - Reset mid-frame discards the partial byte; no error pulse is generated.
- Input conditioning
  - 2-FF synchroniser on ps2_clk and ps2_data.
  - Filtered clock toggles only after FILTER_LEN consecutive samples of the new value.
  - fall = filtered clock 1->0, one-cycle event.
  - Data is sampled from the synchronised ps2_data in the cycle fall is asserted.
- FSM, advancing only on fall unless noted:
  - IDLE: data=0 -> DATA, bit count=0. data=1 -> stay in IDLE and pulse frame_err.
  - DATA: shift LSB-first into shreg[7:0]. After 8 bits -> PARITY.
  - PARITY: check odd parity (^shreg ^ bit == 1); record pass/fail -> STOP.
  - STOP: stop=1 and parity ok -> push shreg. Otherwise pulse frame_err. Either way -> IDLE.
  - Timeout, any state other than IDLE: a counter counts clk cycles since the last fall. On reaching TIMEOUT_CYC: -> IDLE, pulse frame_err, discard the byte. The counter clears on every fall and in IDLE.
- FIFO
  - Pointer width log2(FIFO_DEPTH)+1, wrap-around via the MSB.
  - Push when full: byte dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle are both honoured. Count is unchanged. When full, the push succeeds because the pop frees the slot in the same cycle.
- Output
  - Pop condition: FIFO non-empty and gap counter == 0.
  - The cycle after a pop: kbd_strobe=1 and kbd_data=popped byte.
  - Gap counter loads GAP_CYC-1 on pop and decrements to 0, giving strobe spacing >= GAP_CYC.
- Latency: the first strobe appears 2 clk cycles after the STOP-edge fall when the FIFO was empty and the gap counter was 0 (1 cycle to push, 1 cycle to pop/register).
- busy = (state != IDLE).

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum: ST_IDLE, ST_DATA, ST_PARITY, ST_STOP.
  - Constants PS2_EXT=8'hE0 and PS2_BREAK=8'hF0, for downstream use.
- One natural sub-module: ps2_byte_fifo, a parameterised synchronous FIFO with push, pop, full, empty and dout.
- Synchroniser, filter and FSM stay in the top module.

Test Plan:
- Send frame 0x1C (start 0, LSB-first data, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> exactly one kbd_strobe with kbd_data=8'h1C; frame_err=0.
- Send F0,1C back-to-back -> two strobes in order, 8'hF0 then 8'h1C, spaced >= GAP_CYC (64) cycles.
- Send 0x1C with a wrong parity bit of 1 -> frame_err pulses once, no strobe, busy returns to 0.
- Send 5 frames while GAP_CYC is large enough that nothing is popped -> first 4 bytes delivered in order, overflow pulses once for byte 5, byte 5 never appears.
- Stop ps2_clk after 4 data bits -> frame_err after TIMEOUT_CYC cycles, FSM back in IDLE; a following good frame 0x5A yields a strobe with kbd_data=8'h5A.
- Inject 3-cycle glitches on ps2_clk while idle with FILTER_LEN=8 -> no state change, no frame_err. Then assert reset_n=0 mid-frame -> all outputs 0 and the next good frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 keyboard receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Scan-code prefixes, passed through untouched for the keycode translator.
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_byte_fifo
//  Description : Small synchronous FIFO; extra pointer MSB tells full from empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);

    assign o_dout = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr[AW-1:0]] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_rx
//  Description : PS/2 device-to-host frame receiver with byte FIFO and paced strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 32000,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYC     = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kbd_strobe,
    output logic [7:0] kbd_data,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam int GCW = $clog2(GAP_CYC + 1);

    localparam logic [FCW-1:0] c_FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] c_TMO_LAST  = TCW'(TIMEOUT_CYC - 1);
    localparam logic [GCW-1:0] c_GAP_LAST  = GCW'(GAP_CYC - 1);

    logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic           r_filt, r_filt_q;
    logic [FCW-1:0] r_fcnt;
    logic           w_fall;

    ps2_state_e     r_state, w_state_nxt;
    logic [2:0]     r_bitcnt, w_bitcnt_nxt;
    logic [7:0]     r_shreg, w_shreg_nxt;
    logic           r_par_ok, w_par_ok_nxt;
    logic [TCW-1:0] r_tmo;
    logic           w_tmo_hit;
    logic           w_push, w_err;

    logic           w_pop, w_full, w_empty;
    logic [7:0]     w_dout;
    logic [GCW-1:0] r_gap;
    logic           r_strobe, r_err, r_ovf;
    logic [7:0]     r_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Any sample matching the current filtered level restarts the run count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_filt   <= 1'b1;
            r_filt_q <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_filt_q <= r_filt;
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == c_FILT_LAST) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_fall    = r_filt_q & ~r_filt;
    assign w_tmo_hit = (r_tmo == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_par_ok <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_par_ok <= w_par_ok_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shreg_nxt  = r_shreg;
        w_par_ok_nxt = r_par_ok;
        w_push       = 1'b0;
        w_err        = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nxt  = ST_DATA;
                        w_bitcnt_nxt = '0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_shreg_nxt  = {r_dat_s2, r_shreg[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                end
                ST_PARITY: begin
                    w_par_ok_nxt = odd_parity_ok(r_shreg, r_dat_s2);
                    w_state_nxt  = ST_STOP;
                end
                ST_STOP: begin
                    if (r_dat_s2 && r_par_ok) w_push = 1'b1;
                    else                      w_err  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE && w_tmo_hit) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || r_state == ST_IDLE || w_fall) begin
            r_tmo <= '0;
        end else if (!w_tmo_hit) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_din   (r_shreg),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop = ~w_empty && (r_gap == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_gap    <= '0;
            r_strobe <= 1'b0;
            r_data   <= 8'h00;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop)              r_gap <= c_GAP_LAST;
            else if (r_gap != '0)   r_gap <= r_gap - 1'b1;
            r_strobe <= w_pop;
            if (w_pop) r_data <= w_dout;
            r_err <= w_err;
            r_ovf <= w_push & w_full & ~w_pop;
        end
    end

    assign kbd_strobe = r_strobe;
    assign kbd_data   = r_data;
    assign frame_err  = r_err;
    assign overflow   = r_ovf;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_kbd_rx
//  Description : Directed self-checking bench for ps2_kbd_rx (two gap settings).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int HALF    = 20;    // PS/2 half period in clk cycles
    localparam int TMO     = 500;
    localparam int GAP_B   = 3000;
    localparam int LAT_EXP = 12;    // 2 sync + 8 filter + 1 push + 1 pop

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;

    logic       stb_a, err_a, ovf_a, busy_a;
    logic [7:0] dat_a;
    logic       stb_b, err_b, ovf_b, busy_b;
    logic [7:0] dat_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stop_cyc = 0;

    logic [7:0] qa[$];
    int         ca[$];
    int         erra = 0, ovfa = 0;
    logic [7:0] qb[$];
    int         cb[$];
    int         ovfb = 0;
    logic       busy_seen = 1'b0;

    ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(4), .GAP_CYC(64)) u_a (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kbd_strobe(stb_a), .kbd_data(dat_a), .frame_err(err_a),
        .overflow(ovf_a), .busy(busy_a)
    );

    ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(4), .GAP_CYC(GAP_B)) u_b (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kbd_strobe(stb_b), .kbd_data(dat_b), .frame_err(err_b),
        .overflow(ovf_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (stb_a) begin qa.push_back(dat_a); ca.push_back(cyc); end
        if (err_a) erra++;
        if (ovf_a) ovfa++;
        if (busy_a) busy_seen = 1'b1;
        if (stb_b) begin qb.push_back(dat_b); cb.push_back(cyc); end
        if (ovf_b) ovfb++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_a();
        qa.delete(); ca.delete(); erra = 0; ovfa = 0; busy_seen = 1'b0;
    endtask

    // nbits < 11 leaves the frame unfinished with the clock parked high.
    task automatic send_frame(input logic [7:0] d, input logic par, input int nbits);
        logic [10:0] f;
        f = {1'b1, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ~^d, 11);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        wait_cyc(4);
        reset_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        wait_cyc(3);
        total++; if (stb_a !== 1'b0)   begin bad++; $display("FAIL reset_strobe: got %b want 0", stb_a); end
        total++; if (dat_a !== 8'h00)  begin bad++; $display("FAIL reset_data: got %h want 00", dat_a); end
        total++; if (err_a !== 1'b0)   begin bad++; $display("FAIL reset_err: got %b want 0", err_a); end
        total++; if (ovf_a !== 1'b0)   begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf_a); end
        total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        reset_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_single();
        clear_a();
        send_good(8'h1C);
        wait_cyc(60);
        total++; if (qa.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", qa.size()); end
        else begin
            total++; if (qa[0] !== 8'h1C) begin bad++; $display("FAIL single_data: got %h want 1c", qa[0]); end
            total++; if (ca[0] - stop_cyc != LAT_EXP) begin bad++;
                $display("FAIL single_latency: got %0d want %0d", ca[0] - stop_cyc, LAT_EXP); end
        end
        total++; if (erra != 0) begin bad++; $display("FAIL single_err: got %0d want 0", erra); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_back_to_back();
        clear_a();
        send_good(PS2_BREAK);
        send_good(8'h1C);
        wait_cyc(100);
        total++; if (qa.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", qa.size()); end
        else begin
            total++; if (qa[0] !== 8'hF0) begin bad++; $display("FAIL b2b_first: got %h want f0", qa[0]); end
            total++; if (qa[1] !== 8'h1C) begin bad++; $display("FAIL b2b_second: got %h want 1c", qa[1]); end
            total++; if (ca[1] - ca[0] < 64) begin bad++; $display("FAIL b2b_spacing: got %0d want >=64", ca[1] - ca[0]); end
        end
        total++; if (erra != 0) begin bad++; $display("FAIL b2b_err: got %0d want 0", erra); end
    endtask

    task automatic test_parity();
        clear_a();
        send_frame(8'h1C, 1'b1, 11);
        wait_cyc(60);
        total++; if (erra != 1) begin bad++; $display("FAIL parity_err: got %0d want 1", erra); end
        total++; if (qa.size() != 0) begin bad++; $display("FAIL parity_nostrobe: got %0d want 0", qa.size()); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL parity_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_timeout();
        clear_a();
        send_frame(8'hA5, 1'b1, 5);
        wait_cyc(300);
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL tmo_busy_mid: got %b want 1", busy_a); end
        total++; if (erra != 0) begin bad++; $display("FAIL tmo_early_err: got %0d want 0", erra); end
        wait_cyc(300);
        total++; if (erra != 1) begin bad++; $display("FAIL tmo_err: got %0d want 1", erra); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL tmo_idle: got %b want 0", busy_a); end
        total++; if (qa.size() != 0) begin bad++; $display("FAIL tmo_nostrobe: got %0d want 0", qa.size()); end
        clear_a();
        send_good(8'h5A);
        wait_cyc(60);
        total++; if (qa.size() != 1 || qa[0] !== 8'h5A) begin bad++;
            $display("FAIL tmo_recover: got n=%0d b=%h want n=1 b=5a", qa.size(), (qa.size() > 0) ? qa[0] : 8'hxx); end
    endtask

    task automatic test_glitch();
        clear_a();
        for (int g = 0; g < 4; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(20);
        end
        ps2_clk = 1'b0;            // one sample short of the filter length
        wait_cyc(7);
        ps2_clk = 1'b1;
        wait_cyc(30);
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", busy_seen); end
        total++; if (erra != 0) begin bad++; $display("FAIL glitch_err: got %0d want 0", erra); end
    endtask

    task automatic test_reset_mid();
        clear_a();
        send_frame(8'hFF, 1'b1, 4);
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b want 1", busy_a); end
        reset_n = 1'b0;
        wait_cyc(3);
        total++; if ({stb_a, err_a, ovf_a, busy_a} !== 4'b0000) begin bad++;
            $display("FAIL rmid_flags: got %b want 0000", {stb_a, err_a, ovf_a, busy_a}); end
        total++; if (dat_a !== 8'h00) begin bad++; $display("FAIL rmid_data: got %h want 00", dat_a); end
        reset_n = 1'b1;
        wait_cyc(30);
        send_good(8'h3C);
        wait_cyc(60);
        total++; if (qa.size() != 1 || qa[0] !== 8'h3C) begin bad++;
            $display("FAIL rmid_recover: got n=%0d b=%h want n=1 b=3c", qa.size(), (qa.size() > 0) ? qa[0] : 8'hxx); end
        total++; if (erra != 0) begin bad++; $display("FAIL rmid_err: got %0d want 0", erra); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b [5];
        int         budget;
        exp_b[0] = 8'h00; exp_b[1] = PS2_EXT; exp_b[2] = 8'h12;
        exp_b[3] = 8'h34; exp_b[4] = 8'h56;
        do_reset();
        qb.delete(); cb.delete(); ovfb = 0;
        send_good(8'h00);          // popped at once; starts the long gap
        send_good(PS2_EXT);
        send_good(8'h12);
        send_good(8'h34);
        send_good(8'h56);
        send_good(8'h78);
        budget = 0;
        while (qb.size() < 5 && budget < 20000) begin
            wait_cyc(1);
            budget++;
        end
        if (budget >= 20000) begin
            total++; bad++;
            $display("FAIL ovf_wait: got %0d strobes want 5 before timeout", qb.size());
        end
        wait_cyc(GAP_B + 200);
        total++; if (ovfb != 1) begin bad++; $display("FAIL ovf_pulse: got %0d want 1", ovfb); end
        total++; if (qb.size() != 5) begin bad++; $display("FAIL ovf_count: got %0d want 5", qb.size()); end
        for (int i = 0; i < 5 && i < qb.size(); i++) begin
            total++; if (qb[i] !== exp_b[i]) begin bad++; $display("FAIL ovf_byte%0d: got %h want %h", i, qb[i], exp_b[i]); end
        end
        if (cb.size() >= 2) begin
            total++; if (cb[1] - cb[0] < GAP_B) begin bad++;
                $display("FAIL ovf_spacing: got %0d want >=%0d", cb[1] - cb[0], GAP_B); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
